// File: rtl/sequence_buffer_if.sv
// Handshake bundle for sequence_buffer: controller commands, append port,
// playback stream and player-press compare port.
interface sequence_buffer_if #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             clear;
  logic             append_valid;
  logic [SYM_W-1:0] append_data;
  logic             append_ready;
  logic             full;
  logic [AW:0]      length;
  logic             play_start;
  logic             play_valid;
  logic [SYM_W-1:0] play_data;
  logic             play_last;
  logic             play_ready;
  logic             chk_start;
  logic             chk_valid;
  logic [SYM_W-1:0] chk_data;
  logic             chk_ok;
  logic             chk_fail;
  logic             chk_done;
  logic             busy;

  modport master (
    output clear, append_valid, append_data, play_start, play_ready,
           chk_start, chk_valid, chk_data,
    input  append_ready, full, length, play_valid, play_data, play_last,
           chk_ok, chk_fail, chk_done, busy
  );

  modport slave (
    input  clear, append_valid, append_data, play_start, play_ready,
           chk_start, chk_valid, chk_data,
    output append_ready, full, length, play_valid, play_data, play_last,
           chk_ok, chk_fail, chk_done, busy
  );
endinterface

// File: rtl/sequence_buffer.sv
// Simon-game sequence store: appends symbols, replays the stored sequence
// as a valid/ready stream, and compares player presses against it.
module sequence_buffer #(
  parameter int SYM_W = 2,
  parameter int DEPTH = 16
) (
  input logic clk,
  input logic rst_n,
  sequence_buffer_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] CUR_ONE = AW'(1);

  typedef enum logic [1:0] {IDLE, PLAY, CHECK} state_t;

  state_t           state, state_nxt;
  logic [SYM_W-1:0] mem [DEPTH];
  logic [AW:0]      length, length_nxt, last_idx;
  // Shared position: playback cursor in PLAY, compare index in CHECK.
  logic [AW-1:0]    cursor, cursor_nxt;
  logic             play_valid, play_valid_nxt;
  logic [SYM_W-1:0] play_data, play_data_nxt;
  logic             chk_ok, chk_ok_nxt;
  logic             chk_fail, chk_fail_nxt;
  logic             chk_done, chk_done_nxt;
  logic             full, append_ok, append_fire, at_last, match;

  assign full        = (length == (AW+1)'(DEPTH));
  assign append_ok   = (state == IDLE) && !full && !bus.clear;
  assign append_fire = bus.append_valid && append_ok;
  assign last_idx    = length - LEN_ONE;
  assign at_last     = ({1'b0, cursor} == last_idx);
  assign match       = (bus.chk_data == mem[cursor]);

  assign bus.append_ready = append_ok;
  assign bus.full         = full;
  assign bus.length       = length;
  assign bus.play_valid   = play_valid;
  assign bus.play_data    = play_data;
  assign bus.play_last    = play_valid && at_last;
  assign bus.chk_ok       = chk_ok;
  assign bus.chk_fail     = chk_fail;
  assign bus.chk_done     = chk_done;
  assign bus.busy         = (state != IDLE);

  // Next-state and next-output decode; clear overrides every other input.
  always_comb begin
    state_nxt      = state;
    length_nxt     = append_fire ? (length + LEN_ONE) : length;
    cursor_nxt     = cursor;
    play_valid_nxt = play_valid;
    play_data_nxt  = play_data;
    chk_ok_nxt     = 1'b0;
    chk_fail_nxt   = 1'b0;
    chk_done_nxt   = 1'b0;
    if (bus.clear) begin
      state_nxt      = IDLE;
      length_nxt     = '0;
      play_valid_nxt = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.play_start && (length != '0)) begin
            state_nxt      = PLAY;
            cursor_nxt     = '0;
            play_valid_nxt = 1'b1;
            play_data_nxt  = mem[0];
          end else if (bus.chk_start && (length != '0)) begin
            state_nxt  = CHECK;
            cursor_nxt = '0;
          end
        end
        PLAY: begin
          if (play_valid && bus.play_ready) begin
            if (at_last) begin
              state_nxt      = IDLE;
              play_valid_nxt = 1'b0;
            end else begin
              cursor_nxt    = cursor + CUR_ONE;
              play_data_nxt = mem[cursor_nxt];
            end
          end
        end
        CHECK: begin
          if (bus.chk_valid) begin
            if (match) begin
              chk_ok_nxt = 1'b1;
              if (at_last) begin
                chk_done_nxt = 1'b1;
                state_nxt    = IDLE;
              end else begin
                cursor_nxt = cursor + CUR_ONE;
              end
            end else begin
              chk_fail_nxt = 1'b1;
              state_nxt    = IDLE;
            end
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Length, cursor, playback output and check pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      length     <= '0;
      cursor     <= '0;
      play_valid <= 1'b0;
      play_data  <= '0;
      chk_ok     <= 1'b0;
      chk_fail   <= 1'b0;
      chk_done   <= 1'b0;
    end else begin
      length     <= length_nxt;
      cursor     <= cursor_nxt;
      play_valid <= play_valid_nxt;
      play_data  <= play_data_nxt;
      chk_ok     <= chk_ok_nxt;
      chk_fail   <= chk_fail_nxt;
      chk_done   <= chk_done_nxt;
    end
  end

  // Symbol storage: written at the current length, never reset.
  always_ff @(posedge clk) begin
    if (append_fire) mem[length[AW-1:0]] <= bus.append_data;
  end
endmodule

// File: doc/sequence_buffer.md
# sequence_buffer

Parametrised Simon-game sequence store: accumulates game symbols one at a time, replays the whole stored sequence over a valid/ready stream to the LED/tone driver, and checks player button presses against the stored sequence. It replaces the fixed 2-bit addressed store with length tracking, playback and compare modes. It sits between the game controller FSM (append/start/clear), the random symbol source and the output/input front-ends.

## Interface
- SYM_W, 2, symbol width in bits (one symbol = one colour/button)
- DEPTH, 16, maximum sequence length; power of two, >= 2
- localparam AW = $clog2(DEPTH); length counter is AW+1 bits

- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous: empty the buffer, abort any mode
- append_valid  in  1  append request
- append_data  in  SYM_W  symbol to append
- append_ready  out  1  append accepted this cycle if valid
- full  out  1  length == DEPTH
- length  out  AW+1  number of stored symbols
- play_start  in  1  start playback of entries 0..length-1
- play_valid  out  1  play_data holds a symbol
- play_data  out  SYM_W  symbol being played
- play_last  out  1  play_data is entry length-1
- play_ready  in  1  consumer accepts play_data
- chk_start  in  1  start checking player input from entry 0
- chk_valid  in  1  one player press, single-cycle
- chk_data  in  SYM_W  pressed symbol
- chk_ok  out  1  pulse: press matched
- chk_fail  out  1  pulse: press mismatched, check aborted
- chk_done  out  1  pulse: final entry matched
- busy  out  1  state != IDLE

## Operation
- Storage: DEPTH x SYM_W register array, combinational read, not reset. Write pointer = length.
- States: IDLE, PLAY, CHECK. Reset -> IDLE.
- Append: append_ready = (state==IDLE) && !full && !clear. Accepted append writes mem[length], length += 1. Appends outside IDLE or when full are refused (no write, length unchanged).
- IDLE -> PLAY: play_start && length != 0 (length sampled before the edge). Cursor = 0, play_data loaded with mem[0], play_valid = 1.
- PLAY: transfer = play_valid && play_ready at an edge. Not last: cursor += 1, play_data = mem[cursor+1], play_valid stays 1 (one symbol per cycle). Last: play_valid = 0, -> IDLE. play_last = play_valid && cursor == length-1. play_data holds while play_ready low.
- IDLE -> CHECK: chk_start && length != 0 && !play_start (play_start wins if both). Index = 0.
- CHECK, on chk_valid: chk_data == mem[index] and index < length-1 -> chk_ok, index += 1. Match at index == length-1 -> chk_ok and chk_done, -> IDLE. Mismatch -> chk_fail, -> IDLE. chk_valid outside CHECK ignored.
- clear (any state): length = 0, -> IDLE, play_valid = 0, no chk pulse generated; clear beats every simultaneous input.
- Append and start in same IDLE cycle: both act; playback/check covers the newly appended entry (length compared live).
- start with length == 0: ignored, stays IDLE.

## Timing
- Reset values: length 0, full 0, play_valid 0, play_data 0, play_last 0, chk_ok/chk_fail/chk_done 0, busy 0; append_ready 1 once rst_n high.
- play_valid rises 1 cycle after play_start sampled; n entries drain in n cycles with play_ready held high.
- chk_ok/chk_fail/chk_done are registered, 1-cycle pulses, asserted the cycle after the chk_valid edge; busy drops same edge as the done/fail pulse.
- length/full update the edge after an accepted append; append_ready is combinational from state/full/clear.
- Reset asserted mid-PLAY or mid-CHECK: all outputs to reset values immediately (asynchronous), no pulses.

## Test plan
- DEPTH=4, SYM_W=2: append 3,1,2,0 -> length 4, full 1, append_ready 0; fifth append refused, length stays 4.
- Play with play_ready high -> play_data 3,1,2,0 on 4 consecutive cycles, play_last only on 0, busy low after; append during PLAY refused.
- Play with play_ready toggling 1,0,1,0 -> each symbol held while ready low, no loss/duplication, same 3,1,2,0 order.
- Check 3,1,2,0 -> chk_ok x4, chk_done with last, state IDLE; repeat with 3,2 -> chk_ok then chk_fail on second press, no chk_done.
- clear asserted mid-PLAY after 2 transfers -> play_valid 0 next cycle, length 0, busy 0; subsequent play_start ignored.
- rst_n pulsed low mid-CHECK -> all outputs at reset values without waiting for clk; simultaneous play_start+chk_start with length 2 -> PLAY entered, no chk pulses.
